// File: rtl/delay_line_prog.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_prog
// Description : Runtime-programmable delay line. Delays a WIDTH-bit word and
//               its valid qualifier by 0..MAX_DELAY enabled clock cycles.
//               Supports a stall enable, a synchronous flush and a
//               combinational out-of-range indication on the delay select.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_prog #(
    parameter int               WIDTH     = 8,
    parameter int               MAX_DELAY = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               flush,
    input  logic [$clog2(MAX_DELAY+1)-1:0]     delay_sel,
    input  logic [WIDTH-1:0]                   data_in,
    input  logic                               valid_in,
    output logic [WIDTH-1:0]                   data_out,
    output logic                               valid_out,
    output logic                               sel_err
);

    localparam int c_sw = $clog2(MAX_DELAY + 1);
    localparam logic [c_sw-1:0] c_max = c_sw'(MAX_DELAY);

    // Stage k holds the input sampled k enabled cycles ago.
    logic [WIDTH-1:0] r_data  [1:MAX_DELAY];
    logic             r_valid [1:MAX_DELAY];

    logic [c_sw-1:0]  w_d;
    logic             w_sel_err;

    // Shift register: async reset and sync flush load the idle value,
    // otherwise shift one place per enabled edge and hold when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_data[k]  <= RESET_VAL;
                r_valid[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                r_data[k]  <= RESET_VAL;
                r_valid[k] <= 1'b0;
            end
        end else if (en) begin
            r_data[1]  <= data_in;
            r_valid[1] <= valid_in;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Out-of-range selects are clamped to the deepest stage.
    always_comb begin
        w_sel_err = (delay_sel > c_max);
        w_d       = w_sel_err ? c_max : delay_sel;
    end

    // Output tap: zero delay bypasses the stages entirely, otherwise pick S[d].
    always_comb begin
        data_out  = data_in;
        valid_out = valid_in;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (w_d == c_sw'(k)) begin
                data_out  = r_data[k];
                valid_out = r_valid[k];
            end
        end
    end

    assign sel_err = w_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_line_prog
// Description : Self-checking bench for delay_line_prog. A queue-based history
//               model predicts every output each cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_line_prog;

    localparam int         WIDTH     = 8;
    localparam int         MAX_DELAY = 16;
    localparam logic [7:0] RV        = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [4:0] delay_sel;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       sel_err;

    int n_total;
    int n_pass;

    // History of enabled samples, newest first; entry i is {valid, data}
    // of the sample taken i+1 enabled edges ago.
    logic [8:0] hist[$];

    delay_line_prog #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .delay_sel (delay_sel),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sel_err   (sel_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_clear();
        hist = {};
        repeat (MAX_DELAY) hist.push_back({1'b0, RV});
    endtask

    // Reference model: history of what was captured on each enabled edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            model_clear();
        end else if (en) begin
            hist.push_front({valid_in, data_in});
            void'(hist.pop_back());
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        int         d;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (hist.size() == MAX_DELAY) begin
                d = (int'(delay_sel) > MAX_DELAY) ? MAX_DELAY : int'(delay_sel);
                e = (d == 0) ? {valid_in, data_in} : hist[d-1];
                check("model_data",  {24'd0, data_out},  {24'd0, e[7:0]});
                check("model_valid", {31'd0, valid_out}, {31'd0, e[8]});
                check("model_err",   {31'd0, sel_err},   {31'd0, (int'(delay_sel) > MAX_DELAY)});
            end
        end
    end

    task automatic step(input logic e, input logic f, input logic [4:0] s,
                        input logic [7:0] d, input logic v);
        @(negedge clk);
        en        = e;
        flush     = f;
        delay_sel = s;
        data_in   = d;
        valid_in  = v;
    endtask

    task automatic lit(input string name, input logic [7:0] exp_d, input logic exp_v);
        check({name, "_data"},  {24'd0, data_out},  {24'd0, exp_d});
        check({name, "_valid"}, {31'd0, valid_out}, {31'd0, exp_v});
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        delay_sel = 5'd5;
        data_in   = 8'h00;
        valid_in  = 1'b0;

        // Held in reset: idle value on the tap.
        step(1'b1, 1'b0, 5'd5, 8'h11, 1'b1);
        #3 lit("rst_hold", RV, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with valid words, then reset between edges.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 5'd5, 8'h50 + 8'(i), 1'b1);
        #3 lit("pre_rst", 8'h51, 1'b1);
        rst_n = 1'b0;
        #1 lit("async_rst", RV, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed delay of 3.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 5'd3, 8'(i), 1'b1);
            #3;
            if (i == 4) lit("fixed_first", 8'd1, 1'b1);
            if (i == 5) lit("fixed_second", 8'd2, 1'b1);
            if (i == 8) lit("fixed_fifth", 8'd5, 1'b1);
        end

        // Bypass and clamp.
        step(1'b1, 1'b0, 5'd0, 8'h3C, 1'b1);
        #3 lit("bypass", 8'h3C, 1'b1);
        check("bypass_err", {31'd0, sel_err}, 32'd0);
        step(1'b0, 1'b0, 5'd17, 8'h00, 1'b0);
        #3 check("clamp_err17", {31'd0, sel_err}, 32'd1);
        step(1'b0, 1'b0, 5'd16, 8'h00, 1'b0);
        #3 check("clamp_err16", {31'd0, sel_err}, 32'd0);
        step(1'b0, 1'b0, 5'd31, 8'h00, 1'b0);
        #3 check("clamp_err31", {31'd0, sel_err}, 32'd1);

        // Stall with delay 2.
        step(1'b1, 1'b1, 5'd2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 5'd2, 8'd10, 1'b1);
        step(1'b1, 1'b0, 5'd2, 8'd11, 1'b1);
        #3 lit("stall_b", RV, 1'b0);
        step(1'b0, 1'b0, 5'd2, 8'hEE, 1'b1);
        #3 lit("stall_c", 8'd10, 1'b1);
        step(1'b0, 1'b0, 5'd2, 8'hEE, 1'b1);
        #3 lit("stall_d", 8'd10, 1'b1);
        step(1'b1, 1'b0, 5'd2, 8'd12, 1'b1);
        #3 lit("stall_e", 8'd10, 1'b1);
        step(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        #3 lit("stall_f", 8'd11, 1'b1);
        step(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        #3 lit("stall_g", 8'd12, 1'b1);
        step(1'b1, 1'b0, 5'd2, 8'h00, 1'b0);
        #3 lit("stall_h", 8'h00, 1'b0);

        // Flush has priority over enable and drops the input word.
        step(1'b1, 1'b1, 5'd4, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 5'd4, 8'h20 + 8'(i), 1'b1);
        step(1'b1, 1'b1, 5'd4, 8'h77, 1'b1);
        #3 lit("pre_flush", 8'h21, 1'b1);
        for (int s = 1; s <= MAX_DELAY; s++) begin
            step(1'b0, 1'b0, 5'(s), 8'h00, 1'b0);
            #3 lit("flushed_tap", RV, 1'b0);
        end

        // Bubbles at delay 4, then move the tap to 6.
        step(1'b1, 1'b1, 5'd4, 8'h00, 1'b0);
        step(1'b1, 1'b0, 5'd4, 8'h31, 1'b1);
        step(1'b1, 1'b0, 5'd4, 8'h32, 1'b0);
        step(1'b1, 1'b0, 5'd4, 8'h33, 1'b1);
        step(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
        step(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
        #3 lit("bub_1", 8'h31, 1'b1);
        step(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
        #3 lit("bub_0", 8'h32, 1'b0);
        step(1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
        #3 lit("bub_1b", 8'h33, 1'b1);
        step(1'b1, 1'b0, 5'd6, 8'h00, 1'b0);
        #3 lit("replay_0", 8'h32, 1'b0);
        step(1'b1, 1'b0, 5'd6, 8'h00, 1'b0);
        #3 lit("replay_1", 8'h33, 1'b1);
        step(1'b1, 1'b0, 5'd6, 8'h00, 1'b0);
        #3 lit("replay_end", 8'h00, 1'b0);

        step(1'b0, 1'b0, 5'd6, 8'h00, 1'b0);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
